// File: rtl/frame_buf_writer_pkg.sv
// Shared state type, default output-word layout and the buffer-rotation helper
// used by the frame buffer write packer.
package frame_buf_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 29;

    // Word layout {last_unit_burst, end_line, valid, burst_addr, data}, data at bit 0.
    localparam int WORD_W   = DATA_W_DEF + ADDR_W_DEF + 3;
    localparam int ADDR_LSB = DATA_W_DEF;
    localparam int VAL_BIT  = ADDR_LSB + ADDR_W_DEF;
    localparam int EOL_BIT  = VAL_BIT + 1;
    localparam int LUB_BIT  = EOL_BIT + 1;

    // Step to the following buffer, hopping over the one the reader holds.
    function automatic logic [1:0] next_buf(input logic [1:0] idx,
                                            input logic [1:0] rd,
                                            input int         n);
        int nxt;
        nxt = (int'(idx) + 1) % n;
        if (nxt == int'(rd)) begin
            nxt = (nxt + 1) % n;
        end
        return 2'(nxt);
    endfunction

endpackage

// File: rtl/frame_buf_writer_if.sv
// Beat input / FIFO output bundle between the pixel packer, the writer and the
// DDR write command FIFO.
interface frame_buf_writer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 29
);
    logic                     valid_data_ddr;
    logic [DATA_W-1:0]        data_ddr;
    logic                     fifo_full;
    logic                     fifo_wr;
    logic [DATA_W+ADDR_W+2:0] data_fifo_frame;

    modport master (
        output valid_data_ddr,
        output data_ddr,
        output fifo_full,
        input  fifo_wr,
        input  data_fifo_frame
    );

    modport slave (
        input  valid_data_ddr,
        input  data_ddr,
        input  fifo_full,
        output fifo_wr,
        output data_fifo_frame
    );
endinterface

// File: rtl/frame_buf_writer_burst_line_counter.sv
// Beat / burst / line position inside a frame, with terminal-count flags taken
// from the current (registered) counts.
module burst_line_counter #(
    parameter int BURST_LEN       = 32,
    parameter int BURSTS_PER_LINE = 20,
    parameter int LINES_PER_FRAME = 720
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic beat_tc,
    output logic burst_tc,
    output logic line_tc
);
    localparam int BEAT_W  = (BURST_LEN > 1)       ? $clog2(BURST_LEN)       : 1;
    localparam int BURST_W = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
    localparam int LINE_W  = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    logic [BEAT_W-1:0]  beat_cnt_q,  beat_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [LINE_W-1:0]  line_cnt_q,  line_cnt_d;

    assign beat_tc  = (beat_cnt_q  == BEAT_W'(BURST_LEN - 1));
    assign burst_tc = (burst_cnt_q == BURST_W'(BURSTS_PER_LINE - 1));
    assign line_tc  = (line_cnt_q  == LINE_W'(LINES_PER_FRAME - 1));

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        line_cnt_d  = line_cnt_q;
        if (clr) begin
            beat_cnt_d  = '0;
            burst_cnt_d = '0;
            line_cnt_d  = '0;
        end else if (adv) begin
            if (!beat_tc) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end else begin
                beat_cnt_d = '0;
                if (!burst_tc) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    burst_cnt_d = '0;
                    line_cnt_d  = line_tc ? '0 : line_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            line_cnt_q  <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

endmodule

// File: rtl/frame_buf_writer.sv
// DDR frame-buffer write packer: tags each pixel beat with its burst address and
// burst/line flags, rotates frames across buffers and flags aborts and overflow.
module frame_buf_writer
    import frame_buf_pkg::*;
#(
    parameter int DATA_W          = 64,
    parameter int ADDR_W          = 29,
    parameter int BURST_LEN       = 32,
    parameter int BURSTS_PER_LINE = 20,
    parameter int LINES_PER_FRAME = 720,
    parameter int ADDR_STEP       = 32,
    parameter int NUM_BUF         = 3
) (
    input  logic                      clk_100,
    input  logic                      reset,
    frame_buf_writer_if.slave         bus,
    input  logic                      start_frame,
    input  logic [NUM_BUF*ADDR_W-1:0] reg_addr_buf,
    input  logic [1:0]                rd_buf_idx,
    output logic                      last_burst,
    output logic                      end_frame,
    output logic [1:0]                frame_done_idx,
    output logic [1:0]                wr_buf_idx,
    output logic                      frame_abort,
    output logic                      overflow,
    output logic                      busy
);
    localparam int WORD_W_L = DATA_W + ADDR_W + 3;

    // Base table padded to four entries so the 2-bit index never runs off the end.
    logic [ADDR_W-1:0] base [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_base
            if (gi < NUM_BUF) begin : g_used
                assign base[gi] = reg_addr_buf[gi*ADDR_W +: ADDR_W];
            end else begin : g_unused
                assign base[gi] = '0;
            end
        end
    endgenerate

    state_t                state_q, state_d;
    logic [1:0]            wr_buf_idx_q, wr_buf_idx_d;
    logic [ADDR_W-1:0]     burst_addr_q, burst_addr_d;
    logic                  last_burst_q, last_burst_d;
    logic                  fifo_wr_q, fifo_wr_d;
    logic [WORD_W_L-1:0]   word_q, word_d;
    logic                  end_frame_q, end_frame_d;
    logic [1:0]            frame_done_idx_q, frame_done_idx_d;
    logic                  frame_abort_q, frame_abort_d;
    logic                  overflow_q, overflow_d;

    logic       beat_acc;
    logic       frame_last;
    logic       cnt_clr;
    logic       beat_tc, burst_tc, line_tc;
    logic [1:0] nxt_idx;

    burst_line_counter #(
        .BURST_LEN       (BURST_LEN),
        .BURSTS_PER_LINE (BURSTS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_cnt (
        .clk      (clk_100),
        .rst      (reset),
        .clr      (cnt_clr),
        .adv      (beat_acc),
        .beat_tc  (beat_tc),
        .burst_tc (burst_tc),
        .line_tc  (line_tc)
    );

    // A beat coinciding with start_frame belongs to no frame and is dropped.
    assign beat_acc   = (state_q == ACTIVE) && bus.valid_data_ddr && !start_frame;
    assign frame_last = beat_acc && beat_tc && last_burst_q;
    assign cnt_clr    = start_frame || frame_last;
    assign nxt_idx    = next_buf(wr_buf_idx_q, rd_buf_idx, NUM_BUF);

    always_comb begin
        state_d          = state_q;
        wr_buf_idx_d     = wr_buf_idx_q;
        burst_addr_d     = burst_addr_q;
        last_burst_d     = last_burst_q;
        fifo_wr_d        = beat_acc;
        word_d           = word_q;
        end_frame_d      = frame_last;
        frame_done_idx_d = frame_last ? wr_buf_idx_q : 2'd0;
        frame_abort_d    = start_frame && (state_q == ACTIVE);
        overflow_d       = overflow_q | (fifo_wr_q & bus.fifo_full);

        if (beat_acc) begin
            word_d = {beat_tc, beat_tc & burst_tc, 1'b1, burst_addr_q, bus.data_ddr};
            if (beat_tc) begin
                burst_addr_d = burst_addr_q + ADDR_W'(ADDR_STEP);
            end
        end

        if (start_frame) begin
            state_d      = ACTIVE;
            wr_buf_idx_d = nxt_idx;
            burst_addr_d = base[nxt_idx];
            last_burst_d = 1'b0;
        end else if (frame_last) begin
            state_d      = IDLE;
            last_burst_d = 1'b0;
        end else if ((state_q == ACTIVE) && line_tc && burst_tc) begin
            // Counters already point at the final burst of the frame.
            last_burst_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            wr_buf_idx_q     <= 2'(NUM_BUF - 1);
            burst_addr_q     <= '0;
            last_burst_q     <= 1'b0;
            fifo_wr_q        <= 1'b0;
            word_q           <= '0;
            end_frame_q      <= 1'b0;
            frame_done_idx_q <= 2'd0;
            frame_abort_q    <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_buf_idx_q     <= wr_buf_idx_d;
            burst_addr_q     <= burst_addr_d;
            last_burst_q     <= last_burst_d;
            fifo_wr_q        <= fifo_wr_d;
            word_q           <= word_d;
            end_frame_q      <= end_frame_d;
            frame_done_idx_q <= frame_done_idx_d;
            frame_abort_q    <= frame_abort_d;
            overflow_q       <= overflow_d;
        end
    end

    assign bus.fifo_wr         = fifo_wr_q;
    assign bus.data_fifo_frame = word_q;
    assign last_burst          = last_burst_q;
    assign end_frame           = end_frame_q;
    assign frame_done_idx      = frame_done_idx_q;
    assign wr_buf_idx          = wr_buf_idx_q;
    assign frame_abort         = frame_abort_q;
    assign overflow            = overflow_q;
    assign busy                = (state_q == ACTIVE);

endmodule

// File: tb/tb_frame_buf_writer.sv
// Randomised bench for frame_buf_writer against a frame-position reference model.
module tb_frame_buf_writer;
    import frame_buf_pkg::*;

    localparam int DW    = DATA_W_DEF;
    localparam int AW    = ADDR_W_DEF;
    localparam int WW    = WORD_W;
    localparam int BL    = 4;
    localparam int BPL   = 2;
    localparam int LPF   = 2;
    localparam int STEP  = 32;
    localparam int NB    = 3;
    localparam int TOTAL = BL * BPL * LPF;

    logic             clk_100 = 1'b0;
    logic             reset;
    logic             start_frame;
    logic [NB*AW-1:0] reg_addr_buf;
    logic [1:0]       rd_buf_idx;
    logic             last_burst, end_frame, frame_abort, overflow, busy;
    logic [1:0]       frame_done_idx, wr_buf_idx;
    logic [AW-1:0]    bases [NB];

    frame_buf_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    frame_buf_writer #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .BURSTS_PER_LINE(BPL),
        .LINES_PER_FRAME(LPF), .ADDR_STEP(STEP), .NUM_BUF(NB)
    ) dut (
        .clk_100        (clk_100),
        .reset          (reset),
        .bus            (bus),
        .start_frame    (start_frame),
        .reg_addr_buf   (reg_addr_buf),
        .rd_buf_idx     (rd_buf_idx),
        .last_burst     (last_burst),
        .end_frame      (end_frame),
        .frame_done_idx (frame_done_idx),
        .wr_buf_idx     (wr_buf_idx),
        .frame_abort    (frame_abort),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk_100 = ~clk_100;

    assign bases[0] = AW'(32'h1000);
    assign bases[1] = AW'(32'h2000);
    assign bases[2] = AW'(32'h3000);
    assign reg_addr_buf = {bases[2], bases[1], bases[0]};

    int            tests = 0;
    int            fails = 0;
    int            m_buf;
    int            m_k;
    bit            m_active;
    logic [WW-1:0] m_word_last;

    function automatic int m_next();
        int n;
        n = (m_buf + 1) % NB;
        if (n == int'(rd_buf_idx)) n = (n + 1) % NB;
        return n;
    endfunction

    // Beat k of a frame lives in burst k/BL; flags follow from its position.
    function automatic logic [WW-1:0] m_word(int k, logic [DW-1:0] d);
        logic [WW-1:0] w;
        int            b;
        b = k / BL;
        w = '0;
        w[DW-1:0]         = d;
        w[ADDR_LSB +: AW] = bases[m_buf] + AW'(b * STEP);
        w[VAL_BIT]        = 1'b1;
        w[LUB_BIT]        = ((k % BL) == BL - 1);
        w[EOL_BIT]        = ((k % BL) == BL - 1) && ((b % BPL) == BPL - 1);
        return w;
    endfunction

    task automatic drive(input logic sf, input logic v, input logic [DW-1:0] d);
        start_frame        = sf;
        bus.valid_data_ddr = v;
        bus.data_ddr       = d;
        @(negedge clk_100);
    endtask

    task automatic begin_frame();
        bit was_active;
        was_active = m_active;
        drive(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        m_buf = m_next();
        m_k = 0;
        m_active = 1'b1;
        tests++;
        if ({frame_abort, end_frame, bus.fifo_wr, busy, wr_buf_idx, bus.data_fifo_frame} !==
            {was_active, 1'b0, 1'b0, 1'b1, 2'(m_buf), m_word_last}) begin
            fails++;
            $display("FAIL start: got abort=%b ef=%b wr=%b busy=%b buf=%0d want abort=%b ef=0 wr=0 busy=1 buf=%0d",
                     frame_abort, end_frame, bus.fifo_wr, busy, wr_buf_idx, was_active, m_buf);
        end
    endtask

    task automatic send_beat();
        logic [DW-1:0] d;
        logic [WW-1:0] exp_w;
        bit            last;
        d = {$urandom, $urandom};
        drive(1'b0, 1'b1, d);
        if (m_active) begin
            exp_w = m_word(m_k, d);
            last  = (m_k == TOTAL - 1);
            tests++;
            if ({bus.fifo_wr, bus.data_fifo_frame, end_frame} !== {1'b1, exp_w, last}) begin
                fails++;
                $display("FAIL beat%0d: got wr=%b word=%h ef=%b want wr=1 word=%h ef=%b",
                         m_k, bus.fifo_wr, bus.data_fifo_frame, end_frame, exp_w, last);
            end
            if (last) begin
                tests++;
                if ({frame_done_idx, busy} !== {2'(m_buf), 1'b0}) begin
                    fails++;
                    $display("FAIL frame_end: got idx=%0d busy=%b want idx=%0d busy=0",
                             frame_done_idx, busy, m_buf);
                end
            end
            if (m_k != TOTAL - BL - 1 && m_k != TOTAL - 1) begin
                tests++;
                if (last_burst !== (m_k >= TOTAL - BL)) begin
                    fails++;
                    $display("FAIL last_burst beat%0d: got %b want %b", m_k, last_burst, m_k >= TOTAL - BL);
                end
            end
            m_word_last = exp_w;
            m_k++;
            if (last) m_active = 1'b0;
        end else begin
            tests++;
            if ({bus.fifo_wr, end_frame, busy, bus.data_fifo_frame} !== {1'b0, 1'b0, 1'b0, m_word_last}) begin
                fails++;
                $display("FAIL idle_beat: got wr=%b ef=%b busy=%b word=%h want wr=0 ef=0 busy=0 word=%h",
                         bus.fifo_wr, end_frame, busy, bus.data_fifo_frame, m_word_last);
            end
        end
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, {$urandom, $urandom});
        tests++;
        if ({bus.fifo_wr, end_frame, frame_abort, busy, bus.data_fifo_frame} !==
            {1'b0, 1'b0, 1'b0, m_active, m_word_last}) begin
            fails++;
            $display("FAIL idle: got wr=%b ef=%b abort=%b busy=%b word=%h want wr=0 ef=0 abort=0 busy=%b word=%h",
                     bus.fifo_wr, end_frame, frame_abort, busy, bus.data_fifo_frame, m_active, m_word_last);
        end
        if (!m_active) begin
            tests++;
            if (last_burst !== 1'b0) begin
                fails++;
                $display("FAIL idle_last_burst: got %b want 0", last_burst);
            end
        end
    endtask

    task automatic model_reset();
        m_buf = NB - 1;
        m_k = 0;
        m_active = 1'b0;
        m_word_last = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_frame = 1'b0;
        bus.valid_data_ddr = 1'b0;
        bus.data_ddr = '0;
        bus.fifo_full = 1'b0;
        rd_buf_idx = 2'd2;
        model_reset();
        repeat (3) @(negedge clk_100);
        tests++;
        if ({bus.fifo_wr, bus.data_fifo_frame, last_burst, end_frame, frame_done_idx,
             frame_abort, overflow, busy, wr_buf_idx} !== {1'b0, {WW{1'b0}}, 6'd0, 1'b0, 1'b0, 2'd2}) begin
            fails++;
            $display("FAIL reset: got wr=%b word=%h lb=%b ef=%b idx=%0d ab=%b ov=%b busy=%b buf=%0d want all 0 buf=2",
                     bus.fifo_wr, bus.data_fifo_frame, last_burst, end_frame, frame_done_idx,
                     frame_abort, overflow, busy, wr_buf_idx);
        end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_nominal();
        begin_frame();
        tests++;
        if (wr_buf_idx !== 2'd0) begin
            fails++;
            $display("FAIL nominal_buf: got %0d want 0", wr_buf_idx);
        end
        repeat (TOTAL) send_beat();
        idle_cycle();
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL nominal_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_buffer_skip();
        logic [1:0] want [2];
        want[0] = 2'd1;
        want[1] = 2'd0;
        for (int f = 0; f < 2; f++) begin
            begin_frame();
            tests++;
            if (wr_buf_idx !== want[f]) begin
                fails++;
                $display("FAIL skip_buf%0d: got %0d want %0d", f, wr_buf_idx, want[f]);
            end
            repeat (TOTAL) send_beat();
            idle_cycle();
        end
    endtask

    task automatic test_abort();
        begin_frame();
        repeat (6) send_beat();
        begin_frame();
        send_beat();
        tests++;
        if (frame_abort !== 1'b0) begin
            fails++;
            $display("FAIL abort_pulse_width: got %b want 0", frame_abort);
        end
        repeat (TOTAL - 1) send_beat();
        idle_cycle();
    endtask

    task automatic test_gapped();
        begin_frame();
        repeat (TOTAL) begin
            send_beat();
            idle_cycle();
        end
    endtask

    task automatic test_overflow();
        bus.fifo_full = 1'b1;
        repeat (2) idle_cycle();
        bus.fifo_full = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_no_write: got %b want 0", overflow);
        end
        begin_frame();
        repeat (5) send_beat();
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_early: got %b want 0", overflow);
        end
        send_beat();
        bus.fifo_full = 1'b1;
        send_beat();
        bus.fifo_full = 1'b0;
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_set: got %b want 1", overflow);
        end
        repeat (TOTAL - 7) send_beat();
        idle_cycle();
        begin_frame();
        repeat (TOTAL) send_beat();
        idle_cycle();
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: got %b want 1", overflow);
        end
    endtask

    task automatic test_mid_frame_reset();
        begin_frame();
        repeat (9) send_beat();
        start_frame = 1'b0;
        bus.valid_data_ddr = 1'b1;
        bus.data_ddr = {$urandom, $urandom};
        #2 reset = 1'b1;
        #1;
        model_reset();
        tests++;
        if ({bus.fifo_wr, bus.data_fifo_frame, last_burst, end_frame, frame_done_idx,
             frame_abort, overflow, busy, wr_buf_idx} !== {1'b0, {WW{1'b0}}, 6'd0, 1'b0, 1'b0, 2'd2}) begin
            fails++;
            $display("FAIL midreset: got wr=%b word=%h lb=%b ef=%b idx=%0d ab=%b ov=%b busy=%b buf=%0d want all 0 buf=2",
                     bus.fifo_wr, bus.data_fifo_frame, last_burst, end_frame, frame_done_idx,
                     frame_abort, overflow, busy, wr_buf_idx);
        end
        repeat (2) @(negedge clk_100);
        reset = 1'b0;
        repeat (3) send_beat();
        begin_frame();
        tests++;
        if (wr_buf_idx !== 2'd0) begin
            fails++;
            $display("FAIL midreset_buf: got %0d want 0", wr_buf_idx);
        end
        repeat (TOTAL) send_beat();
        idle_cycle();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            rd_buf_idx = 2'($urandom_range(0, NB - 1));
            begin_frame();
            repeat (TOTAL) begin
                repeat ($urandom_range(0, 2)) idle_cycle();
                send_beat();
            end
            idle_cycle();
        end
        rd_buf_idx = 2'd2;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_buffer_skip();
        test_abort();
        test_gapped();
        test_overflow();
        test_mid_frame_reset();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
